// File: rtl/enigma_pkg.sv
// enigma_pkg: shared constants, types and helpers for the enigma QoS merge stage.
//   clog2_min1 - ceil(log2(n)), never less than 1 (index fields are at least one bit)
//   AGE_CNT_W  - width of the per-channel starvation age counters
//   sb_vec_t   - in-flight ID scoreboard, one bit per {channel, id}, sized for
//                the default configuration (2 channels, 5-bit IDs)
package enigma_pkg;

    localparam int AGE_CNT_W = 8;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_OID_W = clog2_min1(2) + 5;

    typedef logic [(1 << DEF_OID_W)-1:0] sb_vec_t;

endpackage

// File: rtl/enigma_rr_arb.sv
// enigma_rr_arb: combinational QoS arbiter with round-robin tie breaking.
// The highest eff_qos among requesting channels wins; among equal QoS the
// first requester at or after ptr (cyclically) wins.
//   req       - per-channel request (already qualified by the caller)
//   eff_qos   - per-channel effective QoS, channel k at [k*QOS_W +: QOS_W]
//   ptr       - round-robin start channel
//   grant     - one-hot grant (all zero when nothing requests)
//   grant_idx - index of the granted channel (0 when nothing requests)
module enigma_rr_arb
    import enigma_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int QOS_W  = 2,
    localparam int CH_W  = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH*QOS_W-1:0] eff_qos,
    input  logic [CH_W-1:0]         ptr,
    output logic [NUM_CH-1:0]       grant,
    output logic [CH_W-1:0]         grant_idx
);

    logic             found;
    logic [QOS_W-1:0] best;
    int               idx;

    // Scanning from ptr and replacing only on strictly higher QoS keeps the
    // first channel at or after ptr among the equal-best requesters.
    always_comb begin
        found     = 1'b0;
        best      = '0;
        idx       = 0;
        grant_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(ptr) + i) % NUM_CH;
            if (req[idx] && (!found || eff_qos[idx*QOS_W +: QOS_W] > best)) begin
                found     = 1'b1;
                best      = eff_qos[idx*QOS_W +: QOS_W];
                grant_idx = CH_W'(idx);
            end
        end
        grant = found ? (NUM_CH'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/enigma_qos_mux.sv
// enigma_qos_mux: NUM_CH-to-1 merge with QoS priority, round-robin among
// equal QoS, age-based starvation promotion and in-flight ID tracking.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid/in_ready     - per-channel request handshake (in_ready one-hot)
//   in_payload/id/qos     - per-channel request fields, channel k in slice k
//   out_valid/out_ready   - registered output handshake
//   out_payload/id/qos    - winner payload, {channel, id}, original QoS
//   rel_valid/rel_id      - downstream release of an outstanding {channel, id}
//   outst_cnt             - number of outstanding IDs
//   err                   - sticky protocol error (bad release)
module enigma_qos_mux
    import enigma_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int PLD_W   = 128,
    parameter int ID_W    = 5,
    parameter int QOS_W   = 2,
    parameter int AGE_MAX = 16,
    localparam int CH_W   = clog2_min1(NUM_CH),
    localparam int OID_W  = CH_W + ID_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [NUM_CH*PLD_W-1:0] in_payload,
    input  logic [NUM_CH*ID_W-1:0]  in_id,
    input  logic [NUM_CH*QOS_W-1:0] in_qos,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PLD_W-1:0]        out_payload,
    output logic [OID_W-1:0]        out_id,
    output logic [QOS_W-1:0]        out_qos,
    input  logic                    rel_valid,
    input  logic [OID_W-1:0]        rel_id,
    output logic [OID_W:0]          outst_cnt,
    output logic                    err
);

    localparam int SB_N = 1 << OID_W;

    logic [SB_N-1:0]          busy;
    logic [SB_N-1:0]          busy_nxt;
    logic [AGE_CNT_W-1:0]     age [NUM_CH];
    logic [CH_W-1:0]          ptr;

    logic                     slot_can_load;
    logic [NUM_CH-1:0]        blocked;
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH*QOS_W-1:0]  eff_qos;
    logic [NUM_CH-1:0]        grant;
    logic [CH_W-1:0]          grant_idx;
    logic                     do_grant;
    logic [OID_W-1:0]         grant_oid;
    logic                     rel_bad_ch;
    logic                     rel_hit;
    logic                     rel_err;

    assign slot_can_load = !out_valid || out_ready;

    // Per-channel qualification. A channel whose head ID is outstanding only
    // drops out itself; the other channels still compete.
    always_comb begin
        blocked = '0;
        eff_qos = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            blocked[k] = busy[{CH_W'(k), in_id[k*ID_W +: ID_W]}];
            eff_qos[k*QOS_W +: QOS_W] = (age[k] >= AGE_CNT_W'(AGE_MAX))
                                        ? {QOS_W{1'b1}} : in_qos[k*QOS_W +: QOS_W];
        end
    end

    // rst_n gates requests so nothing is accepted while reset is held.
    assign req = in_valid & ~blocked & {NUM_CH{slot_can_load & rst_n}};

    enigma_rr_arb #(
        .NUM_CH (NUM_CH),
        .QOS_W  (QOS_W)
    ) u_arb (
        .req       (req),
        .eff_qos   (eff_qos),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign in_ready  = grant;
    assign do_grant  = |grant;
    assign grant_oid = {grant_idx, in_id[int'(grant_idx)*ID_W +: ID_W]};

    // Releases naming a channel that does not exist never match the
    // scoreboard and are flagged as errors.
    assign rel_bad_ch = {1'b0, rel_id[OID_W-1 -: CH_W]} >= (CH_W+1)'(NUM_CH);
    assign rel_hit    = rel_valid && busy[rel_id] && !rel_bad_ch;
    assign rel_err    = rel_valid && (!busy[rel_id] || rel_bad_ch);

    // A successful release and a grant always target different entries, since
    // a grant requires its entry to be clear and a release requires it set.
    always_comb begin
        busy_nxt = busy;
        if (rel_hit) begin
            busy_nxt[rel_id] = 1'b0;
        end
        if (do_grant) begin
            busy_nxt[grant_oid] = 1'b1;
        end
    end

    // Output slot, scoreboard, counters and pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_payload <= '0;
            out_id      <= '0;
            out_qos     <= '0;
            busy        <= '0;
            outst_cnt   <= '0;
            err         <= 1'b0;
            ptr         <= '0;
        end else begin
            if (slot_can_load) begin
                out_valid <= do_grant;
                if (do_grant) begin
                    out_payload <= in_payload[int'(grant_idx)*PLD_W +: PLD_W];
                    out_id      <= grant_oid;
                    out_qos     <= in_qos[int'(grant_idx)*QOS_W +: QOS_W];
                end
            end
            busy <= busy_nxt;
            if (do_grant && !rel_hit) begin
                outst_cnt <= outst_cnt + (OID_W+1)'(1);
            end else if (!do_grant && rel_hit) begin
                outst_cnt <= outst_cnt - (OID_W+1)'(1);
            end
            if (rel_err) begin
                err <= 1'b1;
            end
            if (do_grant) begin
                ptr <= (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + CH_W'(1);
            end
        end
    end

    // Starvation ages: a waiting channel that could have competed ages; one
    // held by its own outstanding ID does not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                age[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!in_valid[k] || grant[k]) begin
                    age[k] <= '0;
                end else if (!blocked[k] && !(&age[k])) begin
                    age[k] <= age[k] + AGE_CNT_W'(1);
                end
            end
        end
    end

endmodule
